// File: rtl/procb_writer.sv
// Writer front end of the per-thread procb record buffer: accepts a thread-tagged
// record stream and loads one batch per thread, stalling while the slot is full.
module procb_writer #(
    parameter int N_THREADS       = 16,
    parameter int N_THREADS_MSB   = 3,
    parameter int PROCB_A_WIDTH   = 4,
    parameter int PROCB_N_RECORDS = 8,
    parameter int PROCB_D_WIDTH   = 16,
    parameter int FIN_BIT         = 15
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic [N_THREADS_MSB:0]     in_thread_num,
    input  logic [PROCB_D_WIDTH-1:0]   in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [N_THREADS_MSB:0]     wr_thread_num,
    output logic                       wr_en,
    output logic [PROCB_D_WIDTH-1:0]   din,
    input  logic [PROCB_A_WIDTH-1:0]   wr_cnt,
    input  logic                       buf_err,
    output logic                       busy,
    output logic                       done,
    output logic [PROCB_A_WIDTH-1:0]   batch_cnt,
    output logic                       err
);

    // state    | meaning
    // ST_IDLE  | waiting for a record to open a batch
    // ST_SETUP | one cycle for the buffer's wr_cnt to follow the new thread
    // ST_WRITE | streaming records of the latched thread into its slot
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;

    localparam logic [PROCB_A_WIDTH-1:0] N_REC = PROCB_A_WIDTH'(PROCB_N_RECORDS);

    generate
        if (N_THREADS > 2 ** (N_THREADS_MSB + 1) ||
            PROCB_N_RECORDS != 2 ** (PROCB_A_WIDTH - 1)) begin : g_bad_params
            $error("procb_writer: inconsistent thread or record-count parameters");
        end
    endgenerate

    logic [1:0]                 state_q, state_d;
    logic [N_THREADS_MSB:0]     thread_q, thread_d;
    logic [PROCB_A_WIDTH-1:0]   batch_q, batch_d;
    logic                       done_q, done_d;
    logic                       err_q, err_d;

    logic thread_match;
    logic not_full;
    logic ready_c;
    logic wr_en_c;

    // Full is wr_cnt reaching the slot size, i.e. the count MSB being set.
    assign thread_match = (in_thread_num == thread_q);
    assign not_full     = (wr_cnt < N_REC);
    assign ready_c      = (state_q == ST_WRITE) && not_full && thread_match;
    assign wr_en_c      = in_valid && ready_c;

    always_comb begin
        state_d  = state_q;
        thread_d = thread_q;
        batch_d  = batch_q;
        done_d   = 1'b0;
        err_d    = err_q | buf_err;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    thread_d = in_thread_num;
                    batch_d  = '0;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (wr_en_c) begin
                    if (batch_q < N_REC) begin
                        batch_d = batch_q + 1'b1;
                    end
                    if (in_data[FIN_BIT]) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (in_valid && !thread_match) begin
                    // Foreign-thread record is left on the input to open the next batch.
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= ST_IDLE;
            thread_q <= '0;
            batch_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            thread_q <= thread_d;
            batch_q  <= batch_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign in_ready      = ready_c;
    assign wr_en         = wr_en_c;
    assign din           = in_data;
    assign wr_thread_num = thread_q;
    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;
    assign batch_cnt     = batch_q;
    assign err           = err_q;

endmodule

// File: tb/tb_procb_writer.sv
// Bench for procb_writer: behavioural per-thread buffer with registered wr_cnt,
// scoreboard of expected {thread, slot, data} writes, and directed batches.
module tb_procb_writer;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [3:0]  in_thread_num = '0;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  wr_thread_num;
    logic        wr_en;
    logic [15:0] din;
    logic [3:0]  wr_cnt;
    logic        buf_err = 1'b0;
    logic        busy;
    logic        done;
    logic [3:0]  batch_cnt;
    logic        err;

    always #5 CLK = ~CLK;

    procb_writer dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .in_thread_num (in_thread_num),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .wr_thread_num (wr_thread_num),
        .wr_en         (wr_en),
        .din           (din),
        .wr_cnt        (wr_cnt),
        .buf_err       (buf_err),
        .busy          (busy),
        .done          (done),
        .batch_cnt     (batch_cnt),
        .err           (err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    // Buffer model: per-thread counts, wr_cnt registered for the thread seen last edge.
    logic [3:0]  bcnt [16];
    logic [3:0]  m_nxt;
    logic        m_init = 1'b1;
    logic        set_req = 1'b0;
    logic [3:0]  set_thr = '0;
    logic [3:0]  set_val = '0;
    logic [22:0] act_q [$];
    logic [22:0] exp_q [$];
    logic [19:0] stim_q [$];
    logic [3:0]  exp_cnt [16];
    int          done_cnt = 0;

    always @(posedge CLK) begin
        if (m_init) begin
            for (int i = 0; i < 16; i++) bcnt[i] <= '0;
            wr_cnt <= '0;
        end else begin
            m_nxt = bcnt[wr_thread_num];
            if (wr_en) begin
                act_q.push_back({wr_thread_num, m_nxt[2:0], din});
                m_nxt = m_nxt + 4'd1;
            end
            if (set_req && set_thr == wr_thread_num) m_nxt = set_val;
            bcnt[wr_thread_num] <= m_nxt;
            if (set_req && set_thr != wr_thread_num) bcnt[set_thr] <= set_val;
            wr_cnt <= m_nxt;
        end
    end

    always @(negedge CLK) begin
        if (done === 1'b1) done_cnt++;
        while (act_q.size() > 0) begin
            if (exp_q.size() == 0) begin
                check_eq("wr_unexpected", act_q.pop_front(), 23'h7fffff);
            end else begin
                check_eq("wr_rec", act_q.pop_front(), exp_q.pop_front());
            end
        end
    end

    task automatic add_rec(input logic [3:0] t, input logic [15:0] d);
        stim_q.push_back({t, d});
    endtask

    task automatic run_batch(input int err_at, output int iters);
        int stall;
        logic [3:0] t;
        stall = 0;
        iters = 0;
        while (stim_q.size() > 0 && iters < 200) begin
            @(negedge CLK);
            set_req       = 1'b0;
            buf_err       = (iters == err_at);
            in_valid      = 1'b1;
            in_thread_num = stim_q[0][19:16];
            in_data       = stim_q[0][15:0];
            #1;
            t = in_thread_num;
            if (bcnt[t][3]) begin
                check_eq("full_ready", {31'd0, in_ready}, 32'd0);
                stall++;
                if (stall == 3) begin
                    set_req    = 1'b1;
                    set_thr    = t;
                    set_val    = 4'd0;
                    exp_cnt[t] = 4'd0;
                    stall      = 0;
                end
            end else if (in_ready) begin
                exp_q.push_back({t, exp_cnt[t][2:0], in_data});
                exp_cnt[t] = exp_cnt[t] + 4'd1;
                void'(stim_q.pop_front());
            end
            iters++;
        end
        if (stim_q.size() != 0) check_eq("batch_timeout", stim_q.size(), 0);
        stim_q.delete();
        @(negedge CLK);
        in_valid = 1'b0;
        buf_err  = 1'b0;
        set_req  = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    int it;
    int d0;

    initial begin
        for (int i = 0; i < 16; i++) exp_cnt[i] = 4'd0;
        repeat (3) @(negedge CLK);
        check_eq("rst_busy", {31'd0, busy}, 0);
        check_eq("rst_ready", {31'd0, in_ready}, 0);
        check_eq("rst_wr_en", {31'd0, wr_en}, 0);
        check_eq("rst_done", {31'd0, done}, 0);
        check_eq("rst_batch_cnt", {28'd0, batch_cnt}, 0);
        check_eq("rst_err", {31'd0, err}, 0);
        check_eq("rst_thread", {28'd0, wr_thread_num}, 0);
        m_init = 1'b0;
        RST_N  = 1'b1;
        @(negedge CLK);

        // T3: three records back to back
        add_rec(4'd3, 16'h0011);
        add_rec(4'd3, 16'h0012);
        add_rec(4'd3, 16'h8013);
        d0 = done_cnt;
        run_batch(-1, it);
        check_eq("t3_iters", it, 5);
        check_eq("t3_batch_cnt", {28'd0, batch_cnt}, 3);
        check_eq("t3_done", done_cnt - d0, 1);
        check_eq("t3_busy", {31'd0, busy}, 0);

        // T5: ten records through an 8-deep slot
        for (int i = 0; i < 10; i++) add_rec(4'd5, 16'h0500 + 16'(i) + ((i == 9) ? 16'h8000 : 16'h0));
        d0 = done_cnt;
        run_batch(-1, it);
        check_eq("t5_batch_cnt", {28'd0, batch_cnt}, 8);
        check_eq("t5_done", done_cnt - d0, 1);
        check_eq("t5_err", {31'd0, err}, 0);

        // T2: slot preloaded to 5
        @(negedge CLK);
        set_req = 1'b1; set_thr = 4'd2; set_val = 4'd5;
        exp_cnt[2] = 4'd5;
        @(negedge CLK);
        set_req = 1'b0;
        for (int i = 0; i < 5; i++) add_rec(4'd2, 16'h0200 + 16'(i) + ((i == 4) ? 16'h8000 : 16'h0));
        d0 = done_cnt;
        run_batch(-1, it);
        check_eq("t2_batch_cnt", {28'd0, batch_cnt}, 5);
        check_eq("t2_done", done_cnt - d0, 1);

        // Thread switch mid-batch
        add_rec(4'd1, 16'h0101);
        add_rec(4'd4, 16'h8104);
        d0 = done_cnt;
        run_batch(-1, it);
        check_eq("mm_iters", it, 7);
        check_eq("mm_err", {31'd0, err}, 1);
        check_eq("mm_thread", {28'd0, wr_thread_num}, 4);
        check_eq("mm_batch_cnt", {28'd0, batch_cnt}, 1);
        check_eq("mm_done", done_cnt - d0, 1);

        // Reset in the middle of a T6 batch
        add_rec(4'd6, 16'h0601);
        add_rec(4'd6, 16'h0602);
        run_batch(-1, it);
        check_eq("rb_busy", {31'd0, busy}, 1);
        check_eq("rb_batch_cnt", {28'd0, batch_cnt}, 2);
        @(negedge CLK);
        in_valid = 1'b1; in_thread_num = 4'd6; in_data = 16'h8603;
        #1;
        check_eq("rb_pre_ready", {31'd0, in_ready}, 1);
        RST_N = 1'b0;
        #1;
        check_eq("rb_ready", {31'd0, in_ready}, 0);
        check_eq("rb_wr_en", {31'd0, wr_en}, 0);
        check_eq("rb_busy_rst", {31'd0, busy}, 0);
        check_eq("rb_batch_rst", {28'd0, batch_cnt}, 0);
        check_eq("rb_err_rst", {31'd0, err}, 0);
        check_eq("rb_thread_rst", {28'd0, wr_thread_num}, 0);
        check_eq("rb_done_rst", {31'd0, done}, 0);
        in_valid = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        add_rec(4'd6, 16'h8603);
        d0 = done_cnt;
        run_batch(-1, it);
        check_eq("ra_batch_cnt", {28'd0, batch_cnt}, 1);
        check_eq("ra_done", done_cnt - d0, 1);
        check_eq("ra_err", {31'd0, err}, 0);

        // buf_err pulse while writing T7
        for (int i = 0; i < 4; i++) add_rec(4'd7, 16'h0700 + 16'(i) + ((i == 3) ? 16'h8000 : 16'h0));
        d0 = done_cnt;
        run_batch(3, it);
        check_eq("be_err", {31'd0, err}, 1);
        check_eq("be_batch_cnt", {28'd0, batch_cnt}, 4);
        check_eq("be_done", done_cnt - d0, 1);
        repeat (2) @(negedge CLK);
        check_eq("be_err_sticky", {31'd0, err}, 1);

        repeat (3) @(negedge CLK);
        check_eq("sb_exp_left", exp_q.size(), 0);
        check_eq("sb_act_left", act_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
